// File: rtl/reg_writeback_queue.sv
// Per-thread register file writeback queue: arbitrates LSU/ALU/CONST results into a small FIFO
// and drains one register write per cycle during CORE_UPDATE, exporting a pending-write map.
module reg_writeback_queue #(
  parameter int         DATA_BITS   = 8,
  parameter int         ADDR_BITS   = 4,
  parameter int         DEPTH       = 4,
  parameter int         RO_BASE     = 13,
  parameter logic [2:0] CORE_UPDATE = 3'b110
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [2:0]                 core_state,
  input  logic                       lsu_valid,
  input  logic [ADDR_BITS-1:0]       lsu_rd,
  input  logic [DATA_BITS-1:0]       lsu_data,
  output logic                       lsu_ready,
  input  logic                       alu_valid,
  input  logic [ADDR_BITS-1:0]       alu_rd,
  input  logic [DATA_BITS-1:0]       alu_data,
  output logic                       alu_ready,
  input  logic                       imm_valid,
  input  logic [ADDR_BITS-1:0]       imm_rd,
  input  logic [DATA_BITS-1:0]       imm_data,
  output logic                       imm_ready,
  output logic                       wr_en,
  output logic [ADDR_BITS-1:0]       wr_addr,
  output logic [DATA_BITS-1:0]       wr_data,
  output logic [2**ADDR_BITS-1:0]    pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ro_err
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int NREG     = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] RO_BASE_W = (ADDR_BITS+1)'(RO_BASE);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [NREG-1:0]     REG0_BIT = {{(NREG-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0][ADDR_BITS-1:0] rd_mem_q, rd_mem_d;
  logic [DEPTH-1:0][DATA_BITS-1:0] data_mem_q, data_mem_d;
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [PTR_BITS-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]             count_q, count_d;
  logic                            wr_en_q, wr_en_d, ro_err_q, ro_err_d;
  logic [ADDR_BITS-1:0]            wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]            wr_data_q, wr_data_d;

  logic                 full_s, sel_valid_s, accept_s, ro_hit_s, push_s, pop_s;
  logic [ADDR_BITS-1:0] sel_rd_s;
  logic [DATA_BITS-1:0] sel_data_s;
  logic [NREG-1:0]      pending_s;

  // Fixed-priority source select; full is judged on the start-of-cycle count only.
  always_comb begin
    full_s      = (count_q == FULL_CNT);
    lsu_ready   = 1'b0;
    alu_ready   = 1'b0;
    imm_ready   = 1'b0;
    sel_valid_s = 1'b0;
    sel_rd_s    = '0;
    sel_data_s  = '0;
    if (lsu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = lsu_rd;
      sel_data_s  = lsu_data;
      lsu_ready   = enable & ~full_s;
    end else if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_data_s  = alu_data;
      alu_ready   = enable & ~full_s;
    end else if (imm_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = imm_rd;
      sel_data_s  = imm_data;
      imm_ready   = enable & ~full_s;
    end else begin
      sel_valid_s = 1'b0;
    end
    accept_s = sel_valid_s & enable & ~full_s;
    ro_hit_s = accept_s & ({1'b0, sel_rd_s} >= RO_BASE_W);
    push_s   = accept_s & ~ro_hit_s;
    pop_s    = enable & (core_state == CORE_UPDATE) & (count_q != '0);
  end

  // FIFO and write-port next state.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_en_d    = pop_s;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ro_err_d   = ro_hit_s;
    if (pop_s) begin
      wr_addr_d         = rd_mem_q[rd_ptr_q];
      wr_data_d         = data_mem_q[rd_ptr_q];
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_BITS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Push after pop: the two never target the same slot since pop needs count!=0 and push !full.
    if (push_s) begin
      rd_mem_d[wr_ptr_q]   = sel_rd_s;
      data_mem_d[wr_ptr_q] = sel_data_s;
      valid_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d             = wr_ptr_q + PTR_BITS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending map: OR of the decoded destination of every live entry.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_s = pending_s | (valid_q[i] ? (REG0_BIT << rd_mem_q[i]) : '0);
    end
  end

  // State registers; synchronous reset discards all in-flight entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_mem_q   <= '0;
      data_mem_q <= '0;
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ro_err_q   <= 1'b0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ro_err_q   <= ro_err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_s;
  assign count   = count_q;
  assign ro_err  = ro_err_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: per-cycle vector table plus a reset-mid-drain sequence.
module tb_reg_writeback_queue;

  localparam logic [2:0] IDL = 3'b000;
  localparam logic [2:0] UPD = 3'b110;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [2:0]  core_state;
  logic        lsu_valid, alu_valid, imm_valid;
  logic [3:0]  lsu_rd, alu_rd, imm_rd;
  logic [7:0]  lsu_data, alu_data, imm_data;
  logic        lsu_ready, alu_ready, imm_ready;
  logic        wr_en, ro_err;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] pending;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_writeback_queue dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .imm_valid(imm_valid), .imm_rd(imm_rd), .imm_data(imm_data), .imm_ready(imm_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .count(count), .ro_err(ro_err)
  );

  // Expected bundle: {lsu_rdy, alu_rdy, imm_rdy, wr_en, wr_addr, wr_data, pending, count, ro_err}
  typedef struct packed {
    logic        rst, en;
    logic [2:0]  st;
    logic        lv;  logic [3:0] lrd; logic [7:0] ld;
    logic        av;  logic [3:0] ard; logic [7:0] ad;
    logic        iv;  logic [3:0] ird; logic [7:0] id;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[48];
  int   nvec = 0;

  task automatic add(input logic rst, input logic en, input logic [2:0] st,
                     input logic lv, input logic [3:0] lrd, input logic [7:0] ld,
                     input logic av, input logic [3:0] ard, input logic [7:0] ad,
                     input logic iv, input logic [3:0] ird, input logic [7:0] id,
                     input logic [2:0] rdy, input logic we, input logic [3:0] wa,
                     input logic [7:0] wd, input logic [15:0] pend, input logic [2:0] cnt,
                     input logic ro);
    vecs[nvec] = '{rst, en, st, lv, lrd, ld, av, ard, ad, iv, ird, id,
                   {rdy, we, wa, wd, pend, cnt, ro}};
    nvec++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; enable = v.en; core_state = v.st;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    imm_valid = v.iv; imm_rd = v.ird; imm_data = v.id;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] outs();
    return {lsu_ready, alu_ready, imm_ready, wr_en, wr_addr, wr_data, pending, count, ro_err};
  endfunction

  initial begin
    vec_t idle_v;
    idle_v = '0;
    // Alu write rd3=0x2A, then drain: wr_en two cycles after acceptance
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h3,8'h2A, 1'b0,4'h0,8'h00, 3'b010,1'b0,4'h0,8'h00,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h0,8'h00,16'h0008,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h3,8'h2A,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h3,8'h2A,16'h0000,3'd0,1'b0);
    // Three sources at once: priority LSU > ALU > IMM, drained in order 1,2,3
    add(1'b0,1'b1,UPD, 1'b1,4'h1,8'h11, 1'b1,4'h2,8'h22, 1'b1,4'h3,8'h33, 3'b100,1'b0,4'h3,8'h2A,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b1,4'h2,8'h22, 1'b1,4'h3,8'h33, 3'b010,1'b0,4'h3,8'h2A,16'h0002,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b1,4'h3,8'h33, 3'b001,1'b1,4'h1,8'h11,16'h0004,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h2,8'h22,16'h0008,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h3,8'h33,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h3,8'h33,16'h0000,3'd0,1'b0);
    // Fill to four outside UPDATE; fifth is refused, even in the cycle a pop happens
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h4,8'h40, 1'b0,4'h0,8'h00, 3'b010,1'b0,4'h3,8'h33,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h5,8'h50, 1'b0,4'h0,8'h00, 3'b010,1'b0,4'h3,8'h33,16'h0010,3'd1,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h6,8'h60, 1'b0,4'h0,8'h00, 3'b010,1'b0,4'h3,8'h33,16'h0030,3'd2,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h7,8'h70, 1'b0,4'h0,8'h00, 3'b010,1'b0,4'h3,8'h33,16'h0070,3'd3,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h8,8'h80, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h3,8'h33,16'h00F0,3'd4,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b1,4'h8,8'h80, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h3,8'h33,16'h00F0,3'd4,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h4,8'h40,16'h00E0,3'd3,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h5,8'h50,16'h00C0,3'd2,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h6,8'h60,16'h0080,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h7,8'h70,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h7,8'h70,16'h0000,3'd0,1'b0);
    // Read-only destination rd14: handshake completes, ro_err pulses, nothing queued
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b1,4'hE,8'h55, 3'b001,1'b0,4'h7,8'h70,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h7,8'h70,16'h0000,3'd0,1'b1);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h7,8'h70,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h7,8'h70,16'h0000,3'd0,1'b0);
    // Same rd twice: pending[5] held until the second write, last value wins
    add(1'b0,1'b1,IDL, 1'b1,4'h5,8'h10, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b100,1'b0,4'h7,8'h70,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b1,4'h5,8'h20, 1'b0,4'h0,8'h00, 3'b010,1'b0,4'h7,8'h70,16'h0020,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h7,8'h70,16'h0020,3'd2,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h5,8'h10,16'h0020,3'd1,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h5,8'h20,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h5,8'h20,16'h0000,3'd0,1'b0);
    // enable low: no accept, no drain, queue held
    add(1'b0,1'b0,UPD, 1'b1,4'h9,8'h99, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h5,8'h20,16'h0000,3'd0,1'b0);
    add(1'b0,1'b1,IDL, 1'b1,4'h9,8'h99, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b100,1'b0,4'h5,8'h20,16'h0000,3'd0,1'b0);
    add(1'b0,1'b0,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h5,8'h20,16'h0200,3'd1,1'b0);
    add(1'b0,1'b1,UPD, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b0,4'h5,8'h20,16'h0200,3'd1,1'b0);
    add(1'b0,1'b1,IDL, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 3'b000,1'b1,4'h9,8'h99,16'h0000,3'd0,1'b0);

    idle_v.rst = 1'b1;
    drive(idle_v);
    next_cycle();
    next_cycle();
    check("reset_state", {28'h0, outs()}, 64'h0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), {28'h0, outs()}, {28'h0, vecs[i].exp});
      next_cycle();
    end

    // Reset mid-drain: four queued, one popped (count=3, wr_en high), then reset
    idle_v = '0;
    idle_v.en = 1'b1;
    idle_v.st = IDL;
    idle_v.av = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle_v.ard = 4'(k + 1);
      idle_v.ad  = 8'(8'hA1 + k);
      drive(idle_v);
      next_cycle();
    end
    idle_v.av = 1'b0;
    idle_v.st = UPD;
    drive(idle_v);
    next_cycle();
    check("mid_drain_count", 64'(count), 64'd3);
    check("mid_drain_wr", {52'h0, wr_en, wr_addr, wr_data[6:0]}, {52'h0, 1'b1, 4'h1, 7'h21});
    check("mid_drain_pending", 64'(pending), 64'h001C);
    idle_v.rst = 1'b1;
    drive(idle_v);
    next_cycle();
    check("rst_count", 64'(count), 64'd0);
    check("rst_wr", {44'h0, wr_en, wr_addr, wr_data, ro_err, 6'h0}, 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    idle_v.rst = 1'b0;
    drive(idle_v);
    next_cycle();
    check("post_rst_no_drain", {60'h0, wr_en, count}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
